// File: rtl/memory_slot_controller.sv
// Request-side controller for the cache key/value slot arrays: fully-associative
// lookup, slot allocation, one-hot write/select strobes and a status/value response.
module memory_slot_controller #(
   parameter int NUM_ENTRIES = 8,
   parameter int KEY_WIDTH   = 16,
   parameter int VALUE_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [1:0]                         req_op,
   input  logic [KEY_WIDTH-1:0]               req_key,
   input  logic [VALUE_WIDTH-1:0]             req_value,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [1:0]                         resp_status,
   output logic [VALUE_WIDTH-1:0]             resp_value,
   output logic [NUM_ENTRIES-1:0]             entry_write_op,
   output logic [NUM_ENTRIES-1:0]             entry_select_op,
   output logic [KEY_WIDTH-1:0]               entry_key_wdata,
   output logic [VALUE_WIDTH-1:0]             entry_value_wdata,
   input  logic [NUM_ENTRIES*KEY_WIDTH-1:0]   entry_key_rdata,
   input  logic [NUM_ENTRIES*VALUE_WIDTH-1:0] entry_value_rdata,
   output logic [NUM_ENTRIES-1:0]             entry_valid,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int OCC_W = $clog2(NUM_ENTRIES+1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_EXEC   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [1:0] OP_GET = 2'b00;
   localparam logic [1:0] OP_PUT = 2'b01;
   localparam logic [1:0] OP_DEL = 2'b10;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_MISS = 2'b01;
   localparam logic [1:0] ST_FULL = 2'b10;
   localparam logic [1:0] ST_BAD  = 2'b11;

   logic [1:0]             state_reg;
   logic [1:0]             op_reg;
   logic [KEY_WIDTH-1:0]   key_reg;
   logic [VALUE_WIDTH-1:0] value_reg;
   logic                   hit_any_reg;
   logic [IDX_W-1:0]       hit_idx_reg;
   logic                   free_any_reg;
   logic [IDX_W-1:0]       free_idx_reg;
   logic [1:0]             status_pend_reg;
   logic [NUM_ENTRIES-1:0] write_op_reg;
   logic [NUM_ENTRIES-1:0] select_op_reg;
   logic [NUM_ENTRIES-1:0] valid_reg;
   logic [OCC_W-1:0]       occ_reg;
   logic                   resp_valid_reg;
   logic [1:0]             resp_status_reg;
   logic [VALUE_WIDTH-1:0] resp_value_reg;

   logic [KEY_WIDTH-1:0]   key_slice   [NUM_ENTRIES];
   logic [VALUE_WIDTH-1:0] value_slice [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] hit_vec;

   // Invalid slots are masked so stale keys left in the arrays never match.
   generate
      for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot
         assign key_slice[gi]   = entry_key_rdata[gi*KEY_WIDTH +: KEY_WIDTH];
         assign value_slice[gi] = entry_value_rdata[gi*VALUE_WIDTH +: VALUE_WIDTH];
         assign hit_vec[gi]     = valid_reg[gi] && (key_slice[gi] == key_reg);
      end
   endgenerate

   logic             hit_any_next;
   logic [IDX_W-1:0] hit_idx_next;
   logic             free_any_next;
   logic [IDX_W-1:0] free_idx_next;

   // Descending scan so the lowest matching / free index wins.
   always_comb begin
      hit_any_next  = 1'b0;
      hit_idx_next  = '0;
      free_any_next = 1'b0;
      free_idx_next = '0;
      for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit_any_next = 1'b1;
            hit_idx_next = IDX_W'(i);
         end
         if (!valid_reg[i]) begin
            free_any_next = 1'b1;
            free_idx_next = IDX_W'(i);
         end
      end
   end

   logic [NUM_ENTRIES-1:0] write_op_next;
   logic [NUM_ENTRIES-1:0] select_op_next;
   logic [1:0]             status_next;

   always_comb begin
      write_op_next  = '0;
      select_op_next = '0;
      status_next    = ST_OK;
      case (op_reg)
         OP_GET: begin
            if (hit_any_next) select_op_next[hit_idx_next] = 1'b1;
            else              status_next = ST_MISS;
         end
         OP_PUT: begin
            if (hit_any_next)       write_op_next[hit_idx_next]  = 1'b1;
            else if (free_any_next) write_op_next[free_idx_next] = 1'b1;
            else                    status_next = ST_FULL;
         end
         OP_DEL: begin
            if (hit_any_next) select_op_next[hit_idx_next] = 1'b1;
            else              status_next = ST_MISS;
         end
         default: status_next = ST_BAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         op_reg          <= OP_GET;
         key_reg         <= '0;
         value_reg       <= '0;
         hit_any_reg     <= 1'b0;
         hit_idx_reg     <= '0;
         free_any_reg    <= 1'b0;
         free_idx_reg    <= '0;
         status_pend_reg <= ST_OK;
         write_op_reg    <= '0;
         select_op_reg   <= '0;
         valid_reg       <= '0;
         occ_reg         <= '0;
         resp_valid_reg  <= 1'b0;
         resp_status_reg <= ST_OK;
         resp_value_reg  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  op_reg    <= req_op;
                  key_reg   <= req_key;
                  value_reg <= req_value;
                  state_reg <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               hit_any_reg     <= hit_any_next;
               hit_idx_reg     <= hit_idx_next;
               free_any_reg    <= free_any_next;
               free_idx_reg    <= free_idx_next;
               status_pend_reg <= status_next;
               write_op_reg    <= write_op_next;
               select_op_reg   <= select_op_next;
               state_reg       <= S_EXEC;
            end
            S_EXEC: begin
               write_op_reg    <= '0;
               select_op_reg   <= '0;
               resp_valid_reg  <= 1'b1;
               resp_status_reg <= status_pend_reg;
               resp_value_reg  <= (op_reg == OP_GET && hit_any_reg) ? value_slice[hit_idx_reg] : '0;
               if (op_reg == OP_PUT && !hit_any_reg && free_any_reg) begin
                  valid_reg[free_idx_reg] <= 1'b1;
                  occ_reg                 <= occ_reg + OCC_W'(1);
               end else if (op_reg == OP_DEL && hit_any_reg) begin
                  valid_reg[hit_idx_reg] <= 1'b0;
                  occ_reg                <= occ_reg - OCC_W'(1);
               end
               state_reg <= S_RESP;
            end
            default: begin
               if (resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  state_reg      <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready         = (state_reg == S_IDLE);
   assign resp_valid        = resp_valid_reg;
   assign resp_status       = resp_status_reg;
   assign resp_value        = resp_value_reg;
   assign entry_write_op    = write_op_reg;
   assign entry_select_op   = select_op_reg;
   assign entry_key_wdata   = key_reg;
   assign entry_value_wdata = value_reg;
   assign entry_valid       = valid_reg;
   assign occupancy         = occ_reg;

endmodule
